mc_control_hs: RTL and testbench
================================

MC_CONTROL_HS -- requirements
Module: mc_control_hs

Interface
REQ-001 Parameter OPW, default 6, opcode width (SHALL be >= 6; only the low 6 bits are decoded, all higher bits SHALL be zero for a legal opcode).
REQ-002 Parameter WAIT_MAX, default 15, maximum consecutive memory wait cycles before timeout; legal range 1-255.
REQ-003 Parameter TRAP_ON_ILLEGAL, default 1; 1 = undecoded opcode enters TRAP, 0 = undecoded opcode returns to IFETCH.
REQ-004 clk  in  1  single system clock, all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 opcode  in  OPW  instruction opcode from IR, valid from ID onward.
REQ-007 mem_ready  in  1  memory completes the current read or write this cycle.
REQ-008 RegDst  out  2  write-register select: 0=rt, 1=rd, 2=register 31.
REQ-009 MemtoReg  out  2  write-data select: 0=ALUOut, 1=MDR, 2=PC.
REQ-010 ALUSrcA, RegWrite, MemRead, MemWrite, Branch, PCWrite, IorD, IRWrite, Cond  out  1 each  datapath controls with the existing datapath meanings.
REQ-011 ALUOp, ALUSrcB, PCSource  out  2 each  existing datapath encodings.
REQ-012 state  out  4  current state code, for debug.
REQ-013 trap  out  1  high while in TRAP.
REQ-014 timeout  out  1  sticky, set on memory wait overrun, cleared only by rst.

Function
REQ-015 States and codes: IFETCH=0, ID=1, EX_R=2, WB_R=3, EX_B=4, EX_I=5, MEM_WR=6, MEM_RD=7, MDRTOR=8, JUMP=9, TRAP=15.
REQ-016 Decode in ID: 0x00 -> EX_R; 0x04/0x05 -> EX_B; 0x08/0x0C/0x0D -> EX_I; 0x23/0x2B -> EX_I; 0x02/0x03 -> JUMP; any other value -> TRAP, or IFETCH when TRAP_ON_ILLEGAL=0.
REQ-017 IFETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0; IRWrite and PCWrite SHALL be 1 only in a cycle with mem_ready=1, and the state SHALL advance to ID only in that cycle.
REQ-018 ID: for beq/bne, ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALUOut); no other outputs asserted.
REQ-019 EX_R: ALUSrcA=1, ALUSrcB=0, ALUOp=2; next state WB_R.
REQ-020 EX_I: ALUSrcA=1, ALUSrcB=2; ALUOp=0 for addi/lw/sw, ALUOp=3 for andi/ori; next state MEM_RD for lw, MEM_WR for sw, WB_R otherwise.
REQ-021 WB_R: RegWrite=1, MemtoReg=0, RegDst=1 for R-type and 0 for I-type; next state IFETCH.
REQ-022 EX_B: ALUSrcA=1, ALUSrcB=0, ALUOp=1, Branch=1, Cond=opcode[0], PCSource=1; next state IFETCH.
REQ-023 JUMP: PCWrite=1, PCSource=2; for jal additionally RegWrite=1, RegDst=2, MemtoReg=2; next state IFETCH (1 cycle).
REQ-024 MEM_RD: MemRead=1, IorD=1; advance to MDRTOR on mem_ready=1. MDRTOR: RegWrite=1, MemtoReg=1, RegDst=0; next state IFETCH.
REQ-025 MEM_WR: MemWrite=1, IorD=1; advance to IFETCH on mem_ready=1.
REQ-026 Wait counter (8 bit): cleared on entry to IFETCH, MEM_RD or MEM_WR and on every mem_ready=1; increments each waiting cycle with mem_ready=0; when it would exceed WAIT_MAX, next state TRAP and timeout set.
REQ-027 TRAP: every datapath output 0, trap=1, state held until rst.
REQ-028 All outputs not listed for a state SHALL be 0; outputs are combinational from state, opcode and mem_ready only.
REQ-029 mem_ready asserted outside IFETCH, MEM_RD, MEM_WR SHALL be ignored.
REQ-030 A full instruction costs: R/I-ALU 4 cycles, beq/bne 3, j/jal 3, sw 4, lw 5, each plus memory wait cycles.

Reset
REQ-031 rst=1 SHALL immediately force state=IFETCH, wait counter=0, timeout=0, trap=0, independent of clk.
REQ-032 On rst release the block SHALL begin IFETCH at the next rising edge; rst mid-instruction SHALL abandon it with no further write strobes.

Verification
REQ-033 add (0x00), mem_ready always 1 -> states 0,1,2,3,0; RegWrite=1, RegDst=1 exactly in cycle 4.
REQ-034 lw (0x23), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then MDRTOR with RegWrite=1, MemtoReg=1.
REQ-035 jal (0x03) -> JUMP cycle shows PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2.
REQ-036 WAIT_MAX=3, mem_ready held 0 in IFETCH -> after 4 wait cycles state=15, trap=1, timeout=1, IRWrite never asserted.
REQ-037 Opcode 0x3F with TRAP_ON_ILLEGAL=1 -> ID then TRAP; with 0 -> ID then IFETCH.
REQ-038 rst pulsed asynchronously mid-MEM_WR -> MemWrite drops without a clock edge, state=0, timeout=0.

Source files
------------

// File: rtl/mc_control_hs_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface mc_control_hs_if #(
  parameter int OPW = 6
);
  logic [OPW-1:0] opcode;
  logic           mem_ready;
  logic [1:0]     RegDst;
  logic [1:0]     MemtoReg;
  logic [1:0]     ALUOp;
  logic [1:0]     ALUSrcB;
  logic [1:0]     PCSource;
  logic           ALUSrcA;
  logic           RegWrite;
  logic           MemRead;
  logic           MemWrite;
  logic           Branch;
  logic           PCWrite;
  logic           IorD;
  logic           IRWrite;
  logic           Cond;
  logic [3:0]     state;
  logic           trap;
  logic           timeout;

  modport master (
    input  opcode, mem_ready,
    output RegDst, MemtoReg, ALUOp, ALUSrcB, PCSource,
    output ALUSrcA, RegWrite, MemRead, MemWrite, Branch,
    output PCWrite, IorD, IRWrite, Cond,
    output state, trap, timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  RegDst, MemtoReg, ALUOp, ALUSrcB, PCSource,
    input  ALUSrcA, RegWrite, MemRead, MemWrite, Branch,
    input  PCWrite, IorD, IRWrite, Cond,
    input  state, trap, timeout
  );
endinterface

// File: rtl/mc_control_hs.sv
// Multicycle MIPS-style controller with memory handshake,
// wait-cycle timeout and trap state.
module mc_control_hs #(
  parameter int OPW             = 6,
  parameter int WAIT_MAX        = 15,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input logic            clk,
  input logic            rst,
  mc_control_hs_if.master bus
);

  typedef enum logic [3:0] {
    IFETCH = 4'd0,
    ID     = 4'd1,
    EX_R   = 4'd2,
    WB_R   = 4'd3,
    EX_B   = 4'd4,
    EX_I   = 4'd5,
    MEM_WR = 4'd6,
    MEM_RD = 4'd7,
    MDRTOR = 4'd8,
    JUMP   = 4'd9,
    TRAP   = 4'd15
  } state_t;

  state_t     st_q, st_n;
  logic [7:0] wcnt;
  logic       tmo;

  logic [5:0] op;
  logic       op_ok;
  logic       is_r, is_b, is_i, is_j;
  logic       is_lw, is_sw, is_log, is_jal;

  assign op    = bus.opcode[5:0];
  assign op_ok = (bus.opcode >> 6) == '0;

  assign is_r   = op_ok && (op == 6'h00);
  assign is_b   = op_ok && (op == 6'h04 || op == 6'h05);
  assign is_log = op_ok && (op == 6'h0C || op == 6'h0D);
  assign is_lw  = op_ok && (op == 6'h23);
  assign is_sw  = op_ok && (op == 6'h2B);
  assign is_i   = (op_ok && op == 6'h08) || is_log || is_lw || is_sw;
  assign is_jal = op_ok && (op == 6'h03);
  assign is_j   = (op_ok && op == 6'h02) || is_jal;

  // Only the three memory-facing states ever wait on mem_ready.
  logic waiting, stall, over;
  assign waiting = (st_q == IFETCH) || (st_q == MEM_RD) ||
                   (st_q == MEM_WR);
  assign stall   = waiting && !bus.mem_ready;
  assign over    = stall && (({1'b0, wcnt} + 9'd1) > 9'(WAIT_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IFETCH;
      wcnt <= 8'd0;
      tmo  <= 1'b0;
    end else begin
      st_q <= st_n;
      wcnt <= (stall && !over) ? wcnt + 8'd1 : 8'd0;
      if (over)
        tmo <= 1'b1;
    end
  end

  always_comb begin
    st_n         = st_q;
    bus.RegDst   = 2'd0;
    bus.MemtoReg = 2'd0;
    bus.ALUOp    = 2'd0;
    bus.ALUSrcB  = 2'd0;
    bus.PCSource = 2'd0;
    bus.ALUSrcA  = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Branch   = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.IorD     = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.Cond     = 1'b0;
    unique case (st_q)
      IFETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'd1;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        if (bus.mem_ready)
          st_n = ID;
        else if (over)
          st_n = TRAP;
      end
      ID: begin
        if (is_b)
          bus.ALUSrcB = 2'd3;
        unique case (1'b1)
          is_r:    st_n = EX_R;
          is_b:    st_n = EX_B;
          is_i:    st_n = EX_I;
          is_j:    st_n = JUMP;
          default: st_n = TRAP_ON_ILLEGAL ? TRAP : IFETCH;
        endcase
      end
      EX_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'd2;
        st_n        = WB_R;
      end
      WB_R: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = is_r ? 2'd1 : 2'd0;
        st_n         = IFETCH;
      end
      EX_B: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUOp    = 2'd1;
        bus.Branch   = 1'b1;
        bus.Cond     = op[0];
        bus.PCSource = 2'd1;
        st_n         = IFETCH;
      end
      EX_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
        bus.ALUOp   = is_log ? 2'd3 : 2'd0;
        if (is_lw)
          st_n = MEM_RD;
        else if (is_sw)
          st_n = MEM_WR;
        else
          st_n = WB_R;
      end
      MEM_WR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        if (bus.mem_ready)
          st_n = IFETCH;
        else if (over)
          st_n = TRAP;
      end
      MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.mem_ready)
          st_n = MDRTOR;
        else if (over)
          st_n = TRAP;
      end
      MDRTOR: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 2'd1;
        st_n         = IFETCH;
      end
      JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'd2;
        if (is_jal) begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 2'd2;
          bus.MemtoReg = 2'd2;
        end
        st_n = IFETCH;
      end
      TRAP:    st_n = TRAP;
      default: st_n = TRAP;
    endcase
  end

  assign bus.state   = st_q;
  assign bus.trap    = (st_q == TRAP);
  assign bus.timeout = tmo;

endmodule

// File: tb/tb_mc_control_hs.sv
// Bench for mc_control_hs: random instruction stream against an
// instruction-level plan model, plus directed corner cases.
module tb_mc_control_hs;

  localparam int WMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_control_hs_if #(.OPW(6)) a ();
  mc_control_hs_if #(.OPW(8)) b ();

  mc_control_hs #(.WAIT_MAX(WMAX)) u0 (
    .clk(clk), .rst(rst), .bus(a)
  );
  mc_control_hs #(.OPW(8), .TRAP_ON_ILLEGAL(1'b0)) u1 (
    .clk(clk), .rst(rst), .bus(b)
  );

  int checks = 0;
  int errors = 0;

  int plan_st[$];
  bit plan_mr[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [19:0] obs_a();
    return {a.RegDst, a.MemtoReg, a.ALUSrcA, a.RegWrite, a.MemRead,
            a.MemWrite, a.Branch, a.PCWrite, a.IorD, a.IRWrite,
            a.Cond, a.ALUOp, a.ALUSrcB, a.PCSource, a.trap};
  endfunction

  // Required control word for each state, straight from the state table.
  function automatic logic [19:0] exp_out(int st, logic [5:0] op, bit mr);
    logic [1:0] rd = 0, m2r = 0, aop = 0, srcb = 0, pcs = 0;
    bit srca = 0, rw = 0, mrd = 0, mwr = 0, br = 0;
    bit pcw = 0, iord = 0, irw = 0, cnd = 0, tr = 0;
    case (st)
      0: begin mrd = 1; srcb = 1; irw = mr; pcw = mr; end
      1: if (op == 6'h04 || op == 6'h05) srcb = 3;
      2: begin srca = 1; aop = 2; end
      3: begin rw = 1; rd = (op == 6'h00) ? 2'd1 : 2'd0; end
      4: begin srca = 1; aop = 1; br = 1; cnd = op[0]; pcs = 1; end
      5: begin
        srca = 1; srcb = 2;
        aop = (op == 6'h0C || op == 6'h0D) ? 2'd3 : 2'd0;
      end
      6: begin mwr = 1; iord = 1; end
      7: begin mrd = 1; iord = 1; end
      8: begin rw = 1; m2r = 1; end
      9: begin
        pcw = 1; pcs = 2;
        if (op == 6'h03) begin rw = 1; rd = 2; m2r = 2; end
      end
      15: tr = 1;
      default: ;
    endcase
    return {rd, m2r, srca, rw, mrd, mwr, br, pcw, iord, irw, cnd,
            aop, srcb, pcs, tr};
  endfunction

  task automatic add_wait(int st, int w);
    for (int i = 0; i < w; i++) begin
      plan_st.push_back(st);
      plan_mr.push_back(1'b0);
    end
    plan_st.push_back(st);
    plan_mr.push_back(1'b1);
  endtask

  task automatic add1(int st);
    plan_st.push_back(st);
    plan_mr.push_back(1'($urandom_range(0, 1)));
  endtask

  // Cycle-by-cycle plan of one instruction from its class and wait counts.
  task automatic build(logic [5:0] op);
    add_wait(0, $urandom_range(0, 1));
    add1(1);
    case (op)
      6'h00:               begin add1(2); add1(3); end
      6'h04, 6'h05:        add1(4);
      6'h08, 6'h0C, 6'h0D: begin add1(5); add1(3); end
      6'h23: begin add1(5); add_wait(7, $urandom_range(0, WMAX)); add1(8); end
      6'h2B: begin add1(5); add_wait(6, $urandom_range(0, WMAX)); end
      6'h02, 6'h03:        add1(9);
      default:             begin add1(15); add1(15); end
    endcase
  endtask

  task automatic run_plan(logic [5:0] op);
    int st;
    bit mr;
    while (plan_st.size() > 0) begin
      st = plan_st.pop_front();
      mr = plan_mr.pop_front();
      @(negedge clk);
      a.opcode = op;
      a.mem_ready = mr;
      #1;
      chk("state", a.state, st);
      chk("outs", obs_a(), exp_out(st, op, mr));
      chk("timeout", a.timeout, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    a.mem_ready = 1'b0;
    b.mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_state", a.state, 0);
    chk("rst_timeout", a.timeout, 0);
    chk("rst_trap", a.trap, 0);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal [10];
    logic [5:0] bad [3];
    logic [7:0] ops_b [8];
    int exp_b [8];
    logic [5:0] op;
    legal = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h0C,
              6'h0D, 6'h23, 6'h2B, 6'h02, 6'h03};
    bad   = '{6'h3F, 6'h01, 6'h2A};
    ops_b = '{8'h3F, 8'h3F, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_b = '{1, 0, 1, 0, 1, 2, 3, 0};

    a.opcode = '0;
    a.mem_ready = 1'b0;
    b.opcode = '0;
    b.mem_ready = 1'b1;
    #1;
    chk("init_state", a.state, 0);
    chk("init_timeout", a.timeout, 0);
    chk("init_trap", a.trap, 0);
    chk("init_state_b", b.state, 0);
    #2 rst = 1'b0;

    // Illegal opcodes (incl. nonzero high bits) fall back to IFETCH.
    for (int i = 0; i < 8; i++) begin
      b.opcode = ops_b[i];
      @(negedge clk);
      #1;
      chk("b_state", b.state, exp_b[i]);
      chk("b_trap", b.trap, 0);
      if (exp_b[i] == 3) begin
        chk("b_regwrite", b.RegWrite, 1);
        chk("b_regdst", b.RegDst, 1);
      end
    end

    do_reset();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 10) == 10)
        op = bad[$urandom_range(0, 2)];
      else
        op = legal[$urandom_range(0, 9)];
      build(op);
      run_plan(op);
      if (a.state == 4'd15)
        do_reset();
    end

    // Stalled instruction fetch runs out of wait budget.
    do_reset();
    for (int k = 1; k <= WMAX + 1; k++) begin
      @(negedge clk);
      #1;
      chk("to_state", a.state, (k > WMAX) ? 15 : 0);
      chk("to_irwrite", a.IRWrite, 0);
      chk("to_timeout", a.timeout, (k > WMAX) ? 1 : 0);
      chk("to_trap", a.trap, (k > WMAX) ? 1 : 0);
    end
    @(negedge clk);
    a.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("trap_hold", a.state, 15);
    chk("timeout_sticky", a.timeout, 1);

    // Asynchronous reset in the middle of a stalled store.
    do_reset();
    add_wait(0, 0);
    add1(1);
    add1(5);
    plan_st.push_back(6);
    plan_mr.push_back(1'b0);
    run_plan(6'h2B);
    #2 rst = 1'b1;
    #1;
    chk("mw_memwrite", a.MemWrite, 0);
    chk("mw_state", a.state, 0);
    chk("mw_timeout", a.timeout, 0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
